// File: rtl/timer0_unit.sv
// 8051 Timer/Counter 0 with its SFRs: TCON (TF0/TR0), TMOD low nibble, TL0 and TH0.
// TF0 feeds the interrupt controller and is cleared by its acknowledge.
// Build option: define T0_GATE_EN to implement TMOD.GATE (int0_pin gating).
// Without it GATE reads 0 and ignores writes, so int0_pin has no effect.
module timer0_unit #(
    parameter int unsigned PRESCALE = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sfr_we,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] sfr_rdata,
    output logic       sfr_hit,
    input  logic       t0_pin,
    input  logic       int0_pin,
    input  logic       tf0_ack,
    output logic       tf0
);

    localparam int unsigned   PsW    = $clog2(PRESCALE);
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    localparam logic [7:0] AddrTcon = 8'h88;
    localparam logic [7:0] AddrTmod = 8'h89;
    localparam logic [7:0] AddrTl0  = 8'h8A;
    localparam logic [7:0] AddrTh0  = 8'h8C;

    logic [7:0]     tl0_q, tl0_d;
    logic [7:0]     th0_q, th0_d;
    logic [3:0]     tmod_q, tmod_d;
    logic           tr0_q, tr0_d;
    logic           tf0_q, tf0_d;
    logic [PsW-1:0] ps_q, ps_d;
    logic           t0_s1_q, t0_s2_q, t0_prev_q;
    logic           int0_s1_q, int0_s2_q;

    logic       we_tcon, we_tmod, we_tl0, we_th0;
    logic       tick, t0_fall, gate, count_ev, ovf;
    logic       gate_wr;
    logic [7:0] cnt_tl, cnt_th;

    assign we_tcon = sfr_we && (sfr_addr == AddrTcon);
    assign we_tmod = sfr_we && (sfr_addr == AddrTmod);
    assign we_tl0  = sfr_we && (sfr_addr == AddrTl0);
    assign we_th0  = sfr_we && (sfr_addr == AddrTh0);

    assign tick    = (ps_q == PsLast);
    assign t0_fall = t0_prev_q & ~t0_s2_q;
    assign gate    = tmod_q[3];
    assign count_ev = tr0_q & (~gate | int0_s2_q) & (tmod_q[2] ? t0_fall : tick);
    assign tf0     = tf0_q;

`ifdef T0_GATE_EN
    assign gate_wr = sfr_wdata[3];
`else
    assign gate_wr = 1'b0;
`endif

    // Counter value after one count event in the current mode, and whether it overflows
    always_comb begin
        cnt_tl = tl0_q;
        cnt_th = th0_q;
        ovf    = 1'b0;
        case (tmod_q[1:0])
            2'd0: begin
                cnt_tl = {tl0_q[7:5], tl0_q[4:0] + 5'd1};
                if (tl0_q[4:0] == 5'h1F) begin
                    cnt_th = th0_q + 8'd1;
                    ovf    = (th0_q == 8'hFF);
                end
            end
            2'd1: begin
                {cnt_th, cnt_tl} = {th0_q, tl0_q} + 16'd1;
                ovf = ({th0_q, tl0_q} == 16'hFFFF);
            end
            2'd2: begin
                if (tl0_q == 8'hFF) begin
                    cnt_tl = th0_q;
                    ovf    = 1'b1;
                end else begin
                    cnt_tl = tl0_q + 8'd1;
                end
            end
            default: begin
                // Mode 3: only TL0 runs; TH0 holds
                cnt_tl = tl0_q + 8'd1;
                ovf    = (tl0_q == 8'hFF);
            end
        endcase
    end

    // Next-state: SFR writes beat count updates per byte; overflow beats every TF0 source
    always_comb begin
        ps_d   = tick ? '0 : ps_q + PsW'(1);
        tl0_d  = we_tl0 ? sfr_wdata : (count_ev ? cnt_tl : tl0_q);
        th0_d  = we_th0 ? sfr_wdata : (count_ev ? cnt_th : th0_q);
        tmod_d = we_tmod ? {gate_wr, sfr_wdata[2:0]} : tmod_q;
        tr0_d  = we_tcon ? sfr_wdata[4] : tr0_q;
        if (count_ev && ovf) begin
            tf0_d = 1'b1;
        end else if (we_tcon) begin
            tf0_d = sfr_wdata[5];
        end else if (tf0_ack) begin
            tf0_d = 1'b0;
        end else begin
            tf0_d = tf0_q;
        end
    end

    // State registers, input synchronisers and prescaler
    always_ff @(posedge clock) begin
        if (reset) begin
            tl0_q     <= 8'h00;
            th0_q     <= 8'h00;
            tmod_q    <= 4'h0;
            tr0_q     <= 1'b0;
            tf0_q     <= 1'b0;
            ps_q      <= '0;
            t0_s1_q   <= 1'b1;
            t0_s2_q   <= 1'b1;
            t0_prev_q <= 1'b1;
            int0_s1_q <= 1'b1;
            int0_s2_q <= 1'b1;
        end else begin
            tl0_q     <= tl0_d;
            th0_q     <= th0_d;
            tmod_q    <= tmod_d;
            tr0_q     <= tr0_d;
            tf0_q     <= tf0_d;
            ps_q      <= ps_d;
            t0_s1_q   <= t0_pin;
            t0_s2_q   <= t0_s1_q;
            t0_prev_q <= t0_s2_q;
            int0_s1_q <= int0_pin;
            int0_s2_q <= int0_s1_q;
        end
    end

    // Combinational SFR read mux; live values, 0x00 on a miss
    always_comb begin
        sfr_rdata = 8'h00;
        sfr_hit   = 1'b1;
        case (sfr_addr)
            AddrTcon: sfr_rdata = {2'b00, tf0_q, tr0_q, 4'h0};
            AddrTmod: sfr_rdata = {4'h0, tmod_q};
            AddrTl0:  sfr_rdata = tl0_q;
            AddrTh0:  sfr_rdata = th0_q;
            default:  sfr_hit   = 1'b0;
        endcase
    end

endmodule
